// File: rtl/axis_uart_pkg.sv
// Shared UART types, widths and the parity helper used by the transmitter and receiver.
package axis_uart_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int DIVIDER_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT
  } uart_state_e;

  // Receiver error flags as seen by the status register.
  typedef struct packed {
    logic parity_err;
    logic frame_err;
    logic overrun;
  } uart_rx_status_t;

  // Expected parity bit for a payload; odd parity wins when both modes are enabled.
  function automatic logic parity(input logic [DATA_WIDTH-1:0] data,
                                  input logic                  odd,
                                  input logic                  even);
    logic result;
    result = 1'b0;
    if (odd) begin
      result = ~(^data);
    end else if (even) begin
      result = ^data;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Flop chain that brings an asynchronous level into the clk_i domain.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the chain; reset loads the idle level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain[STAGES-1];

endmodule

// File: rtl/axis_uart_rx.sv
// UART receiver: 8N1/8E1/8O1 deserialiser feeding a one-entry AXI-Stream output register.
module axis_uart_rx #(
  parameter int DATA_WIDTH    = axis_uart_pkg::DATA_WIDTH,
  parameter int DIVIDER_WIDTH = axis_uart_pkg::DIVIDER_WIDTH,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
  input  logic                     parity_odd_i,
  input  logic                     parity_even_i,
  input  logic                     uart_rx_i,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata_o,
  output logic                     m_axis_tvalid_o,
  input  logic                     m_axis_tready_i,
  output logic                     parity_err_o,
  output logic                     frame_err_o,
  output logic                     overrun_o
);

  import axis_uart_pkg::*;

  localparam int                       IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic [DIVIDER_WIDTH-1:0] MIN_DIV  = DIVIDER_WIDTH'(2);
  localparam logic [DIVIDER_WIDTH-1:0] ONE      = DIVIDER_WIDTH'(1);

  logic                     rx_s;
  uart_state_e              state_q, state_d;
  logic [DIVIDER_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIVIDER_WIDTH-1:0] div_q, div_d;
  logic [IDX_W-1:0]         bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0]    shift_q, shift_d;
  logic                     odd_q, odd_d;
  logic                     even_q, even_d;
  logic                     err_q, err_d;
  logic                     byte_good, parity_fail, frame_fail;
  logic [DIVIDER_WIDTH-1:0] bit_end, half_end;
  logic [DATA_WIDTH-1:0]    tdata_q;
  logic                     tvalid_q;
  uart_rx_status_t          status_q;

  sync_ff #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (uart_rx_i),
    .q_o  (rx_s)
  );

  assign bit_end  = div_q - ONE;
  assign half_end = (div_q >> 1) - ONE;

  // Frame sequencing: start qualification, mid-bit sampling, parity and stop checks.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    odd_d       = odd_q;
    even_d      = even_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    err_d       = err_q;
    byte_good   = 1'b0;
    parity_fail = 1'b0;
    frame_fail  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
          div_d   = (clk_divider_i < MIN_DIV) ? MIN_DIV : clk_divider_i;
          odd_d   = parity_odd_i;
          even_d  = parity_even_i;
          err_d   = 1'b0;
        end
      end
      START: begin
        if (cnt_q == half_end) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      DATA: begin
        if (cnt_q == bit_end) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
          if (bit_idx_q == LAST_IDX) begin
            state_d = (odd_q || even_q) ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      PARITY: begin
        if (cnt_q == bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
          if (rx_s != parity(shift_q, odd_q, even_q)) begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      STOP: begin
        if (cnt_q == bit_end) begin
          cnt_d = '0;
          if (!rx_s) begin
            frame_fail = 1'b1;
            state_d    = WAIT;
          end else begin
            if (err_q) begin
              parity_fail = 1'b1;
            end else begin
              byte_good = 1'b1;
            end
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      WAIT: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Frame state and the settings captured at start detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= MIN_DIV;
      bit_idx_q <= '0;
      shift_q   <= '0;
      odd_q     <= 1'b0;
      even_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      odd_q     <= odd_d;
      even_q    <= even_d;
      err_q     <= err_d;
    end
  end

  // Output holding register and single-cycle error pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      status_q <= '0;
    end else begin
      status_q.parity_err <= parity_fail;
      status_q.frame_err  <= frame_fail;
      status_q.overrun    <= byte_good && tvalid_q && !m_axis_tready_i;
      if (byte_good && (!tvalid_q || m_axis_tready_i)) begin
        tdata_q  <= shift_q;
        tvalid_q <= 1'b1;
      end else if (tvalid_q && m_axis_tready_i) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign parity_err_o    = status_q.parity_err;
  assign frame_err_o     = status_q.frame_err;
  assign overrun_o       = status_q.overrun;

endmodule

// File: tb/tb_axis_uart_rx.sv
// Directed bench for axis_uart_rx: table of frames plus hand-written corner sequences.
module tb_axis_uart_rx;

  typedef struct {
    string       name;
    logic        odd;
    logic        even;
    logic [7:0]  data;
    logic        par_bit;
    logic        stop_bit;
    int          div_port;
    int          bit_cycles;
    int          new_div;
    int          exp_beats;
    logic [7:0]  exp_data;
    int          exp_perr;
    int          exp_ferr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] clk_divider;
  logic        parity_odd;
  logic        parity_even;
  logic        rx_line;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        perr;
  logic        ferr;
  logic        ovr;

  int          n_compared   = 0;
  int          n_mismatched = 0;
  int          beats        = 0;
  int          perr_cnt     = 0;
  int          ferr_cnt     = 0;
  int          ovr_cnt      = 0;
  logic [7:0]  last_data    = 8'h00;
  int          b_beats, b_perr, b_ferr, b_ovr;
  int          lat;
  vec_t        vecs[11];
  vec_t        hv;

  axis_uart_rx dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clk_divider_i  (clk_divider),
    .parity_odd_i   (parity_odd),
    .parity_even_i  (parity_even),
    .uart_rx_i      (rx_line),
    .m_axis_tdata_o (tdata),
    .m_axis_tvalid_o(tvalid),
    .m_axis_tready_i(tready),
    .parity_err_o   (perr),
    .frame_err_o    (ferr),
    .overrun_o      (ovr)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Tally handshakes and error pulses just after each falling edge.
  always @(negedge clk) begin
    #1;
    if (tvalid && tready) begin
      beats++;
      last_data = tdata;
    end
    if (perr) perr_cnt++;
    if (ferr) ferr_cnt++;
    if (ovr)  ovr_cnt++;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete (got timeout, required finish)");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic hold(input logic b, input int n);
    rx_line = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] data, input logic with_par, input logic par_bit,
                           input logic stop_bit, input int bc, input int new_div, input logic flip_even);
    hold(1'b0, bc);
    if (new_div != 0) begin
      clk_divider = new_div;
      parity_even = flip_even;
    end
    for (int i = 0; i < 8; i++) hold(data[i], bc);
    if (with_par) hold(par_bit, bc);
    hold(stop_bit, bc);
  endtask

  task automatic applyStimulus(input vec_t v);
    clk_divider = v.div_port;
    parity_odd  = v.odd;
    parity_even = v.even;
    send_bits(v.data, v.odd | v.even, v.par_bit, v.stop_bit, v.bit_cycles, v.new_div, ~v.even);
    hold(1'b1, 40);
    clk_divider = 16;
    parity_odd  = 1'b0;
    parity_even = 1'b0;
  endtask

  task automatic snap();
    b_beats = beats;
    b_perr  = perr_cnt;
    b_ferr  = ferr_cnt;
    b_ovr   = ovr_cnt;
  endtask

  initial begin
    vecs[0]  = '{"nopar_A5",       1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 16, 16, 0, 1, 8'hA5, 0, 0};
    vecs[1]  = '{"even_3C_ok",     1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 16, 16, 0, 1, 8'h3C, 0, 0};
    vecs[2]  = '{"even_3C_bad",    1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 16, 16, 0, 0, 8'h00, 1, 0};
    vecs[3]  = '{"oddeven_01",     1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 16, 16, 0, 1, 8'h01, 0, 0};
    vecs[4]  = '{"odd_01_bad",     1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 16, 16, 0, 0, 8'h00, 1, 0};
    vecs[5]  = '{"nopar_FF",       1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 16, 16, 0, 1, 8'hFF, 0, 0};
    vecs[6]  = '{"nopar_00",       1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16, 16, 0, 1, 8'h00, 0, 0};
    vecs[7]  = '{"even_07_ok",     1'b0, 1'b1, 8'h07, 1'b1, 1'b1, 16, 16, 0, 1, 8'h07, 0, 0};
    vecs[8]  = '{"ferr_over_perr", 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 16, 16, 0, 0, 8'h00, 0, 1};
    vecs[9]  = '{"div1_clamp_C3",  1'b0, 1'b0, 8'hC3, 1'b0, 1'b1,  1,  2, 0, 1, 8'hC3, 0, 0};
    vecs[10] = '{"middiv_96",      1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 16, 16, 5, 1, 8'h96, 0, 0};

    rst         = 1'b1;
    rx_line     = 1'b1;
    tready      = 1'b1;
    clk_divider = 16;
    parity_odd  = 1'b0;
    parity_even = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_tvalid", int'(tvalid), 0);
    checkOutput("reset_tdata",  int'(tdata),  0);
    checkOutput("reset_perr",   int'(perr),   0);
    checkOutput("reset_ferr",   int'(ferr),   0);
    checkOutput("reset_ovr",    int'(ovr),    0);
    hold(1'b1, 10);

    // Latency from line falling edge to tvalid for a plain frame.
    snap();
    lat = 0;
    fork
      applyStimulus(vecs[0]);
      begin
        while (!tvalid && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    checkOutput("latency_in_window", int'(lat >= 150 && lat <= 162), 1);
    checkOutput("latency_beats", beats - b_beats, 1);
    checkOutput("latency_data", int'(last_data), 8'hA5);

    // Table of single frames.
    for (int i = 0; i < 11; i++) begin
      snap();
      applyStimulus(vecs[i]);
      checkOutput({vecs[i].name, "_beats"}, beats - b_beats, vecs[i].exp_beats);
      if (vecs[i].exp_beats > 0)
        checkOutput({vecs[i].name, "_data"}, int'(last_data), int'(vecs[i].exp_data));
      checkOutput({vecs[i].name, "_perr"}, perr_cnt - b_perr, vecs[i].exp_perr);
      checkOutput({vecs[i].name, "_ferr"}, ferr_cnt - b_ferr, vecs[i].exp_ferr);
      checkOutput({vecs[i].name, "_ovr"},  ovr_cnt - b_ovr, 0);
    end

    // Short low glitch is ignored, then a normal frame still decodes.
    snap();
    hold(1'b0, 4);
    hold(1'b1, 40);
    checkOutput("glitch_beats", beats - b_beats, 0);
    checkOutput("glitch_perr",  perr_cnt - b_perr, 0);
    checkOutput("glitch_ferr",  ferr_cnt - b_ferr, 0);
    hv = vecs[0];
    hv.data = 8'h5A;
    applyStimulus(hv);
    checkOutput("glitch_next_beats", beats - b_beats, 1);
    checkOutput("glitch_next_data", int'(last_data), 8'h5A);

    // Stop bit low followed by a long break: one frame error, then recovery.
    snap();
    send_bits(8'h81, 1'b0, 1'b0, 1'b0, 16, 0, 1'b0);
    hold(1'b0, 100);
    checkOutput("break_ferr",  ferr_cnt - b_ferr, 1);
    checkOutput("break_beats", beats - b_beats, 0);
    checkOutput("break_perr",  perr_cnt - b_perr, 0);
    hold(1'b1, 40);
    hv.data = 8'h42;
    applyStimulus(hv);
    checkOutput("break_next_beats", beats - b_beats, 1);
    checkOutput("break_next_data", int'(last_data), 8'h42);
    checkOutput("break_ferr_total", ferr_cnt - b_ferr, 1);

    // Output full: the second back-to-back byte overruns, the first is held.
    snap();
    tready = 1'b0;
    send_bits(8'h11, 1'b0, 1'b0, 1'b1, 16, 0, 1'b0);
    send_bits(8'h22, 1'b0, 1'b0, 1'b1, 16, 0, 1'b0);
    hold(1'b1, 40);
    checkOutput("ovr_tvalid_held", int'(tvalid), 1);
    checkOutput("ovr_tdata_held",  int'(tdata), 8'h11);
    checkOutput("ovr_pulse",       ovr_cnt - b_ovr, 1);
    checkOutput("ovr_no_beat",     beats - b_beats, 0);
    tready = 1'b1;
    hold(1'b1, 5);
    checkOutput("ovr_release_beats", beats - b_beats, 1);
    checkOutput("ovr_release_data", int'(last_data), 8'h11);
    checkOutput("ovr_release_tvalid", int'(tvalid), 0);

    // Reset in the middle of data bit 4 while a byte is held.
    tready = 1'b0;
    hv.data = 8'h33;
    applyStimulus(hv);
    checkOutput("rst_pre_tvalid", int'(tvalid), 1);
    snap();
    hold(1'b0, 16);
    for (int i = 0; i < 4; i++) hold(hv.data[i] ^ 1'b1, 16);
    hold(1'b1, 8);
    rst     = 1'b1;
    rx_line = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_tvalid", int'(tvalid), 0);
    checkOutput("rst_mid_tdata",  int'(tdata), 0);
    rst = 1'b0;
    hold(1'b1, 60);
    checkOutput("rst_mid_perr",  perr_cnt - b_perr, 0);
    checkOutput("rst_mid_ferr",  ferr_cnt - b_ferr, 0);
    checkOutput("rst_mid_ovr",   ovr_cnt - b_ovr, 0);
    checkOutput("rst_mid_beats", beats - b_beats, 0);
    tready = 1'b1;
    hv.data = 8'h7E;
    applyStimulus(hv);
    checkOutput("rst_next_beats", beats - b_beats, 1);
    checkOutput("rst_next_data", int'(last_data), 8'h7E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
